// File: rtl/oven_pkg.sv
// Shared definitions for the microwave oven controller: state encoding and state type.
package oven_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_COOK  = 3'd1;
  localparam state_t ST_PAUSE = 3'd2;
  localparam state_t ST_DONE  = 3'd3;
  localparam state_t ST_ERROR = 3'd4;

endpackage

// File: rtl/oven_pwm.sv
// Power-level PWM: a free-running counter while cooking, compared against the
// captured power level to gate the magnetron.
module oven_pwm #(
  parameter int PWR_LEVELS = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cook_en,
  input  logic                          enter_cook,
  input  logic                          door_closed,
  input  logic [$clog2(PWR_LEVELS)-1:0] pwr,
  output logic                          heat
);

  localparam int PW = $clog2(PWR_LEVELS);
  localparam logic [PW-1:0] CNT_MAX = PW'(PWR_LEVELS - 1);

  logic [PW-1:0] pwm_cnt_q;
  logic [PW-1:0] pwm_cnt_d;

  // Counter next value: restart on COOK entry so every burn begins with the on-phase.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q;
    if (enter_cook) begin
      pwm_cnt_d = {PW{1'b0}};
    end else if (cook_en) begin
      if (pwm_cnt_q == CNT_MAX) begin
        pwm_cnt_d = {PW{1'b0}};
      end else begin
        pwm_cnt_d = pwm_cnt_q + 1'b1;
      end
    end else begin
      pwm_cnt_d = pwm_cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt_q <= {PW{1'b0}};
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

  // Door sense bypasses the register so opening the door kills heat in the same cycle.
  assign heat = cook_en && door_closed && (pwm_cnt_q <= pwr);

endmodule

// File: rtl/oven_ctrl.sv
// Microwave oven controller: cook-time countdown FSM with door interlock,
// pause/resume, error handling and PWM power control.
module oven_ctrl
  import oven_pkg::*;
#(
  parameter int TIME_W     = 8,
  parameter int PWR_LEVELS = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          door_closed,
  input  logic                          start,
  input  logic                          cancel,
  input  logic                          load,
  input  logic [TIME_W-1:0]             load_time,
  input  logic [$clog2(PWR_LEVELS)-1:0] power_lvl,
  input  logic                          tick,
  output logic                          heat,
  output state_t                        state,
  output logic [TIME_W-1:0]             time_left,
  output logic                          done
);

  localparam int PW = $clog2(PWR_LEVELS);

  state_t            state_q, state_d;
  logic [TIME_W-1:0] time_left_q, time_left_d;
  logic [PW-1:0]     pwr_q, pwr_d;
  logic              cook_en;
  logic              enter_cook;

  // State register and captured cook parameters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      time_left_q <= {TIME_W{1'b0}};
      pwr_q       <= {PW{1'b0}};
    end else begin
      state_q     <= state_d;
      time_left_q <= time_left_d;
      pwr_q       <= pwr_d;
    end
  end

  // Next-state and countdown logic; door-open and cancel take precedence over tick in COOK.
  always_comb begin
    state_d     = state_q;
    time_left_d = time_left_q;
    pwr_d       = pwr_q;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          time_left_d = load_time;
          pwr_d       = power_lvl;
        end else if (start) begin
          if (!door_closed) begin
            state_d = ST_ERROR;
          end else if (time_left_q != {TIME_W{1'b0}}) begin
            state_d = ST_COOK;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COOK: begin
        if (!door_closed) begin
          state_d = ST_PAUSE;
        end else if (cancel) begin
          state_d     = ST_IDLE;
          time_left_d = {TIME_W{1'b0}};
        end else if (tick) begin
          if (time_left_q > TIME_W'(1)) begin
            time_left_d = time_left_q - TIME_W'(1);
          end else begin
            time_left_d = {TIME_W{1'b0}};
            state_d     = ST_DONE;
          end
        end else begin
          state_d = ST_COOK;
        end
      end
      ST_PAUSE: begin
        if (cancel) begin
          state_d     = ST_IDLE;
          time_left_d = {TIME_W{1'b0}};
        end else if (start && door_closed) begin
          state_d = ST_COOK;
        end else begin
          state_d = ST_PAUSE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_ERROR: begin
        if (cancel || door_closed) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ERROR;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode; reset masks heat and done even before the state register clears.
  always_comb begin
    cook_en    = (state_q == ST_COOK) && !reset;
    enter_cook = (state_d == ST_COOK) && (state_q != ST_COOK);
    done       = (state_q == ST_DONE) && !reset;
    state      = state_q;
    time_left  = time_left_q;
  end

  oven_pwm #(
    .PWR_LEVELS (PWR_LEVELS)
  ) u_pwm (
    .clk         (clk),
    .reset       (reset),
    .cook_en     (cook_en),
    .enter_cook  (enter_cook),
    .door_closed (door_closed),
    .pwr         (pwr_q),
    .heat        (heat)
  );

endmodule

// File: tb/tb_oven_ctrl.sv
// Self-checking bench for oven_ctrl: directed scenarios followed by random
// stimulus, all compared against a behavioural model of the oven.
module tb_oven_ctrl;

  localparam int TIME_W     = 8;
  localparam int PWR_LEVELS = 4;

  logic       clk;
  logic       reset;
  logic       door_closed;
  logic       start;
  logic       cancel;
  logic       load;
  logic [7:0] load_time;
  logic [1:0] power_lvl;
  logic       tick;
  logic       heat;
  logic [2:0] state;
  logic [7:0] time_left;
  logic       done;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: mode name as an int code, remaining time, power, cycles since COOK entry.
  int m_mode;
  int m_time;
  int m_pwr;
  int m_phase;

  oven_ctrl #(
    .TIME_W     (TIME_W),
    .PWR_LEVELS (PWR_LEVELS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .door_closed (door_closed),
    .start       (start),
    .cancel      (cancel),
    .load        (load),
    .load_time   (load_time),
    .power_lvl   (power_lvl),
    .tick        (tick),
    .heat        (heat),
    .state       (state),
    .time_left   (time_left),
    .done        (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock using the spec's rules directly.
  task automatic model_clock();
    int nm;
    int nt;
    nm = m_mode;
    nt = m_time;
    if (reset) begin
      m_mode = 0; m_time = 0; m_pwr = 0; m_phase = 0;
      return;
    end
    if (m_mode == 0) begin
      if (load) begin
        nt = load_time;
        m_pwr = power_lvl;
      end else if (start) begin
        nm = !door_closed ? 4 : (m_time != 0 ? 1 : 0);
      end
    end else if (m_mode == 1) begin
      if (!door_closed) nm = 2;
      else if (cancel) begin nm = 0; nt = 0; end
      else if (tick) begin
        nt = (m_time > 0) ? m_time - 1 : 0;
        if (nt == 0) nm = 3;
      end
    end else if (m_mode == 2) begin
      if (cancel) begin nm = 0; nt = 0; end
      else if (start && door_closed) nm = 1;
    end else if (m_mode == 3) begin
      nm = 0;
    end else if (m_mode == 4) begin
      if (cancel || door_closed) nm = 0;
    end
    if (nm == 1 && m_mode != 1) m_phase = 0;
    else if (m_mode == 1) m_phase = m_phase + 1;
    m_mode = nm;
    m_time = nt;
  endtask

  // One cycle: drive inputs, check outputs mid-cycle, clock, update model.
  task automatic cyc(input logic r, input logic d, input logic s, input logic c,
                     input logic l, input logic [7:0] lt, input logic [1:0] pl,
                     input logic t);
    logic exp_heat;
    reset = r; door_closed = d; start = s; cancel = c;
    load = l; load_time = lt; power_lvl = pl; tick = t;
    #1;
    exp_heat = (m_mode == 1) && d && !r && ((m_phase % PWR_LEVELS) <= m_pwr);
    chk("state", 32'(state), 32'(m_mode));
    chk("time_left", 32'(time_left), 32'(m_time));
    chk("heat", 32'(heat), 32'(exp_heat));
    chk("done", 32'(done), 32'((m_mode == 3) && !r));
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  initial begin
    m_mode = 0; m_time = 0; m_pwr = 0; m_phase = 0;
    reset = 1'b1; door_closed = 1'b1; start = 1'b0; cancel = 1'b0;
    load = 1'b0; load_time = 8'd0; power_lvl = 2'd0; tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 1'b0);

    // Full cook at max power: load 3, start, three ticks, DONE pulse, back to IDLE.
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd3, 2'd3, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 2'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 1'b1);
    end
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 1'b0);

    // Power 1 pattern, door opens after two ticks, then resume.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd5, 2'd1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 2'd0, 1'b0);
    for (int i = 0; i < 8; i++)
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 1'(i == 3 || i == 7));
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 2'd0, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 2'd0, 1'b0);
    for (int i = 0; i < 5; i++)
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 1'b0);
    // Cancel together with tick in COOK.
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 2'd0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 1'b0);

    // Door open at start goes to ERROR; closing returns to IDLE keeping time.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd4, 2'd2, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 2'd0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd9, 2'd0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 1'b0);
    // Reset then start with zero time stays IDLE.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 2'd0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 1'b0);

    // Reset mid-COOK at time_left 7.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd9, 2'd3, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 2'd0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 1'b0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      cyc(1'($urandom_range(0, 63) == 0),
          1'($urandom_range(0, 99) < 88),
          1'($urandom_range(0, 3) == 0),
          1'($urandom_range(0, 15) == 0),
          1'($urandom_range(0, 7) == 0),
          8'($urandom_range(0, 12)),
          2'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
